// File: rtl/clock_time_ctrl_pkg.sv
// Shared types and constants for the clock timekeeping controller.
//   mode_e : operating mode of the time-set state machine
//   bcd_t  : one BCD digit pair {tens[7:4], ones[3:0]}
//   *_MAX  : last legal value of each field before it wraps to 00
//   bcd_inc: BCD increment of a digit pair, wrapping to 00 after max
package clock_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_e;

  typedef logic [7:0] bcd_t;

  localparam bcd_t SEC_MAX = 8'h59;
  localparam bcd_t MIN_MAX = 8'h59;
  localparam bcd_t HR_MAX  = 8'h23;

  // Wrap is tested before the ones-digit carry so that 23 -> 00 for hours
  // while 19 -> 20 still takes the normal digit carry.
  function automatic bcd_t bcd_inc(input bcd_t v, input bcd_t max_v);
    bcd_t r;
    if (v == max_v)
      r = 8'h00;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/clock_time_ctrl_if.sv
// Control and display bus of the clock timekeeping controller.
//   en, btn_mode, btn_inc : controls toward the controller (level signals)
//   sec_o, min_o, hr_o    : BCD time fields toward the display decoder
//   mode_o                : 0 RUN, 1 SET_HR, 2 SET_MIN
//   tick_o, day_o         : one-cycle update pulses
//   blink_o               : blank phase for the field being set
// master = the panel/display side, slave = the controller.
interface clock_time_if;
  import clock_pkg::*;

  logic       en;
  logic       btn_mode;
  logic       btn_inc;
  bcd_t       sec_o;
  bcd_t       min_o;
  bcd_t       hr_o;
  logic [1:0] mode_o;
  logic       tick_o;
  logic       day_o;
  logic       blink_o;

  modport master (
    output en, btn_mode, btn_inc,
    input  sec_o, min_o, hr_o, mode_o, tick_o, day_o, blink_o
  );

  modport slave (
    input  en, btn_mode, btn_inc,
    output sec_o, min_o, hr_o, mode_o, tick_o, day_o, blink_o
  );

endinterface

// File: rtl/clock_time_ctrl_bcd_mod_counter.sv
// BCD digit-pair counter wrapping to 00 after MAX_BCD.
//   clk, reset : system clock, synchronous active-low reset
//   inc        : advance by one this cycle
//   clr        : force to 00 (wins over inc)
//   value      : registered BCD count
//   carry      : combinational, high when this inc wraps the counter
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter bcd_t MAX_BCD = 8'h59
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output bcd_t value,
  output logic carry
);

  always_ff @(posedge clk) begin
    if (!reset)
      value <= 8'h00;
    else if (clr)
      value <= 8'h00;
    else if (inc)
      value <= bcd_inc(value, MAX_BCD);
  end

  assign carry = inc & (value == MAX_BCD);

endmodule

// File: rtl/clock_time_ctrl.sv
// Single-clock timekeeping controller: 1 Hz prescaler, cascaded BCD
// seconds/minutes/hours counters and a two-button time-set FSM.
//   clk   : system clock
//   reset : synchronous active-low reset
//   bus   : clock_time_if.slave (controls in, time/mode/pulses out)
//
// state   | meaning
// RUN     | time advances on each prescaler wrap, tick_o/day_o pulse
// SET_HR  | btn_inc edge steps hours mod 24, seconds frozen
// SET_MIN | btn_inc edge steps minutes mod 60; leaving clears sec/prescaler
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int HALF_DIV = TICK_DIV / 2
) (
  input  logic        clk,
  input  logic        reset,
  clock_time_if.slave bus
);

  localparam int              PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW:0]     HALF_CMP  = (PW + 1)'(HALF_DIV);

  logic [PW-1:0] presc_q;
  mode_e         mode_q, mode_d;
  logic          mode_hist_q, inc_hist_q;
  logic          tick_q, day_q;

  logic mode_edge, inc_edge;
  logic leave_set_min;
  logic tick_now, day_now;
  logic sec_inc, min_inc, hr_inc;
  logic sec_carry, min_carry, hr_carry;
  bcd_t sec_val, min_val, hr_val;

  // A simultaneous mode edge swallows the increment edge.
  assign mode_edge = bus.btn_mode & ~mode_hist_q;
  assign inc_edge  = bus.btn_inc & ~inc_hist_q & ~mode_edge;

  assign tick_now = (mode_q == RUN) & bus.en & (presc_q == PRESC_MAX);

  // Carries only cascade on a real time tick; manual set steps never
  // ripple into the next field.
  assign sec_inc = tick_now;
  assign min_inc = (tick_now & sec_carry) | ((mode_q == SET_MIN) & inc_edge);
  assign hr_inc  = (tick_now & min_carry) | ((mode_q == SET_HR) & inc_edge);
  assign day_now = tick_now & hr_carry;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q <= RUN;
    end else begin
      mode_q <= mode_d;
    end
  end

  always_comb begin
    mode_d        = mode_q;
    leave_set_min = 1'b0;
    if (mode_edge) begin
      case (mode_q)
        RUN:     mode_d = SET_HR;
        SET_HR:  mode_d = SET_MIN;
        SET_MIN: begin
          mode_d        = RUN;
          leave_set_min = 1'b1;
        end
        default: mode_d = RUN;
      endcase
    end
  end

  // Button history resets high so a button held through reset is not
  // mistaken for a fresh press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc_q     <= '0;
      mode_hist_q <= 1'b1;
      inc_hist_q  <= 1'b1;
      tick_q      <= 1'b0;
      day_q       <= 1'b0;
    end else begin
      mode_hist_q <= bus.btn_mode;
      inc_hist_q  <= bus.btn_inc;
      tick_q      <= tick_now;
      day_q       <= day_now;
      if (leave_set_min)
        presc_q <= '0;
      else if (bus.en)
        presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
    end
  end

  bcd_mod_counter #(.MAX_BCD(SEC_MAX)) u_sec (
    .clk   (clk),
    .reset (reset),
    .inc   (sec_inc),
    .clr   (leave_set_min),
    .value (sec_val),
    .carry (sec_carry)
  );

  bcd_mod_counter #(.MAX_BCD(MIN_MAX)) u_min (
    .clk   (clk),
    .reset (reset),
    .inc   (min_inc),
    .clr   (1'b0),
    .value (min_val),
    .carry (min_carry)
  );

  bcd_mod_counter #(.MAX_BCD(HR_MAX)) u_hr (
    .clk   (clk),
    .reset (reset),
    .inc   (hr_inc),
    .clr   (1'b0),
    .value (hr_val),
    .carry (hr_carry)
  );

  assign bus.sec_o   = sec_val;
  assign bus.min_o   = min_val;
  assign bus.hr_o    = hr_val;
  assign bus.mode_o  = mode_q;
  assign bus.tick_o  = tick_q;
  assign bus.day_o   = day_q;
  assign bus.blink_o = (mode_q != RUN) & ({1'b0, presc_q} < HALF_CMP);

endmodule

// File: tb/tb_clock_time_ctrl.sv
module tb_clock_time_ctrl;

  typedef enum int {OP_RUN, OP_MODE, OP_INC, OP_BOTH} op_e;

  typedef struct {
    string      name;
    op_e        op;
    int         n;
    logic       en;
    logic [7:0] hr;
    logic [7:0] mn;
    logic [7:0] sc;
    logic [1:0] mode;
    int         ticks;
    int         days;
  } vec_t;

  logic clk;
  logic reset;
  clock_time_if bus();

  clock_time_ctrl #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_tick = 0;
  int n_day = 0;
  int n_day_alone = 0;
  int n_blink = 0;
  int n_blink_run = 0;

  vec_t tbl1[$];
  vec_t tbl2[$];
  vec_t sb[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.tick_o) n_tick++;
    if (bus.day_o && bus.tick_o) n_day++;
    if (bus.day_o && !bus.tick_o) n_day_alone++;
    if (bus.blink_o) n_blink++;
    if (bus.blink_o && bus.mode_o == 2'd0) n_blink_run++;
  endtask

  function automatic vec_t mk(input string name, input op_e op, input int n,
                              input logic en, input logic [7:0] hr,
                              input logic [7:0] mn, input logic [7:0] sc,
                              input logic [1:0] mode, input int ticks,
                              input int days);
    vec_t v;
    v.name = name; v.op = op; v.n = n; v.en = en;
    v.hr = hr; v.mn = mn; v.sc = sc; v.mode = mode;
    v.ticks = ticks; v.days = days;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    int t0, d0;
    vec_t e;
    sb.push_back(v);
    t0 = n_tick;
    d0 = n_day;
    bus.en = v.en;
    case (v.op)
      OP_RUN: repeat (v.n) step();
      OP_MODE: repeat (v.n) begin
        bus.btn_mode = 1'b1; step();
        bus.btn_mode = 1'b0; step();
      end
      OP_INC: repeat (v.n) begin
        bus.btn_inc = 1'b1; step();
        bus.btn_inc = 1'b0; step();
      end
      default: repeat (v.n) begin
        bus.btn_mode = 1'b1; bus.btn_inc = 1'b1; step();
        bus.btn_mode = 1'b0; bus.btn_inc = 1'b0; step();
      end
    endcase
    e = sb.pop_front();
    chk({e.name, ".hr"},    bus.hr_o,     e.hr);
    chk({e.name, ".min"},   bus.min_o,    e.mn);
    chk({e.name, ".sec"},   bus.sec_o,    e.sc);
    chk({e.name, ".mode"},  bus.mode_o,   e.mode);
    chk({e.name, ".ticks"}, n_tick - t0,  e.ticks);
    chk({e.name, ".days"},  n_day - d0,   e.days);
  endtask

  initial begin
    int bl0;

    tbl1.push_back(mk("to_sethr",  OP_MODE,   1, 1'b0, 8'h00, 8'h00, 8'h03, 2'd1,  0, 0));
    tbl1.push_back(mk("hr_to22",   OP_INC,   22, 1'b1, 8'h22, 8'h00, 8'h03, 2'd1,  0, 0));
    tbl1.push_back(mk("hr_23",     OP_INC,    1, 1'b1, 8'h23, 8'h00, 8'h03, 2'd1,  0, 0));
    tbl1.push_back(mk("hr_wrap",   OP_INC,    1, 1'b1, 8'h00, 8'h00, 8'h03, 2'd1,  0, 0));
    tbl1.push_back(mk("hr_01",     OP_INC,    1, 1'b1, 8'h01, 8'h00, 8'h03, 2'd1,  0, 0));
    tbl1.push_back(mk("hr_back23", OP_INC,   22, 1'b1, 8'h23, 8'h00, 8'h03, 2'd1,  0, 0));
    tbl1.push_back(mk("to_setmin", OP_MODE,   1, 1'b1, 8'h23, 8'h00, 8'h03, 2'd2,  0, 0));
    tbl1.push_back(mk("min_to59",  OP_INC,   59, 1'b1, 8'h23, 8'h59, 8'h03, 2'd2,  0, 0));
    tbl1.push_back(mk("min_wrap",  OP_INC,    1, 1'b1, 8'h23, 8'h00, 8'h03, 2'd2,  0, 0));
    tbl1.push_back(mk("min_59b",   OP_INC,   59, 1'b1, 8'h23, 8'h59, 8'h03, 2'd2,  0, 0));
    tbl1.push_back(mk("exit_set",  OP_MODE,   1, 1'b0, 8'h23, 8'h59, 8'h00, 2'd0,  0, 0));
    tbl1.push_back(mk("run59s",    OP_RUN,  236, 1'b1, 8'h23, 8'h59, 8'h59, 2'd0, 59, 0));
    tbl1.push_back(mk("day_roll",  OP_RUN,    4, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0,  1, 1));
    tbl1.push_back(mk("enter_hr",  OP_MODE,   1, 1'b0, 8'h00, 8'h00, 8'h00, 2'd1,  0, 0));
    tbl1.push_back(mk("both",      OP_BOTH,   1, 1'b1, 8'h00, 8'h00, 8'h00, 2'd2,  0, 0));

    tbl2.push_back(mk("frozen",    OP_RUN,   20, 1'b0, 8'h00, 8'h00, 8'h01, 2'd0,  0, 0));
    tbl2.push_back(mk("s_hr",      OP_MODE,   1, 1'b0, 8'h00, 8'h00, 8'h01, 2'd1,  0, 0));
    tbl2.push_back(mk("s_hr12",    OP_INC,   12, 1'b0, 8'h12, 8'h00, 8'h01, 2'd1,  0, 0));
    tbl2.push_back(mk("s_min",     OP_MODE,   1, 1'b0, 8'h12, 8'h00, 8'h01, 2'd2,  0, 0));
    tbl2.push_back(mk("s_min34",   OP_INC,   34, 1'b0, 8'h12, 8'h34, 8'h01, 2'd2,  0, 0));
    tbl2.push_back(mk("s_exit",    OP_MODE,   1, 1'b0, 8'h12, 8'h34, 8'h00, 2'd0,  0, 0));
    tbl2.push_back(mk("s_run56",   OP_RUN,  224, 1'b1, 8'h12, 8'h34, 8'h56, 2'd0, 56, 0));
    tbl2.push_back(mk("s_hr2",     OP_MODE,   1, 1'b0, 8'h12, 8'h34, 8'h56, 2'd1,  0, 0));
    tbl2.push_back(mk("s_min2",    OP_MODE,   1, 1'b0, 8'h12, 8'h34, 8'h56, 2'd2,  0, 0));

    // Reset for two edges, then check the reset state.
    reset = 1'b0;
    bus.en = 1'b0;
    bus.btn_mode = 1'b0;
    bus.btn_inc = 1'b0;
    step();
    step();
    chk("rst.hr",   bus.hr_o,   8'h00);
    chk("rst.min",  bus.min_o,  8'h00);
    chk("rst.sec",  bus.sec_o,  8'h00);
    chk("rst.mode", bus.mode_o, 2'd0);
    chk("rst.tick", bus.tick_o, 1'b0);
    chk("rst.day",  bus.day_o,  1'b0);

    // Tick cadence: first pulse on the 4th edge, then every 4th.
    reset = 1'b1;
    bus.en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("tick_seq", bus.tick_o, (i % 4 == 3) ? 1 : 0);
    end
    chk("run12.sec", bus.sec_o, 8'h03);

    for (int i = 0; i < tbl1.size(); i++) apply(tbl1[i]);

    // Leaving SET_MIN: seconds and prescaler clear, first tick 4 edges later.
    bus.en = 1'b1;
    bus.btn_mode = 1'b1;
    step();
    chk("exit.mode", bus.mode_o, 2'd0);
    chk("exit.sec",  bus.sec_o,  8'h00);
    bus.btn_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("exit.no_tick", bus.tick_o, 1'b0);
    end
    step();
    chk("exit.tick4", bus.tick_o, 1'b1);
    chk("exit.sec1",  bus.sec_o,  8'h01);

    for (int i = 0; i < tbl2.size(); i++) apply(tbl2[i]);

    // Reset mid-operation at 12:34:56 in SET_MIN with btn_mode held through it.
    bus.en = 1'b1;
    bus.btn_mode = 1'b1;
    reset = 1'b0;
    step();
    chk("midrst.hr",   bus.hr_o,   8'h00);
    chk("midrst.min",  bus.min_o,  8'h00);
    chk("midrst.sec",  bus.sec_o,  8'h00);
    chk("midrst.mode", bus.mode_o, 2'd0);
    reset = 1'b1;
    repeat (3) step();
    chk("held_rst.mode", bus.mode_o, 2'd0);
    bus.btn_mode = 1'b0;
    bus.en = 1'b0;
    step();

    // Held buttons act once; blink has a 50% duty in set mode.
    bus.en = 1'b1;
    bus.btn_mode = 1'b1;
    step();
    step();
    bl0 = n_blink;
    repeat (8) step();
    chk("held_mode.mode", bus.mode_o, 2'd1);
    chk("blink.count",    n_blink - bl0, 4);
    bus.btn_mode = 1'b0;
    bus.btn_inc = 1'b1;
    repeat (10) step();
    chk("held_inc.hr",   bus.hr_o,   8'h01);
    chk("held_inc.mode", bus.mode_o, 2'd1);
    bus.btn_inc = 1'b0;
    step();

    chk("blink_in_run", n_blink_run, 0);
    chk("day_no_tick",  n_day_alone, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_time_ctrl.md
Name: clock_time_ctrl

Overview:
- Synchronous timekeeping controller for the digital clock.
- Divides the system clock into a 1 Hz tick and sequences the seconds, minutes and hours BCD digit pairs, with cascaded carries and a 23:59:59 -> 00:00:00 rollover.
- Provides a two-button time-set state machine (mode / increment).
- Replaces the ripple-clocked counter chain with a single-clock design that feeds the display decoder.

Parameters:
- TICK_DIV, 1000: clk cycles per second tick; must be >= 2. Use 4 for simulation.
- HALF_DIV, TICK_DIV/2: prescaler threshold for the set-mode blink phase.

Ports:
- clk  in  1  system clock; all state is updated on its rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  prescaler enable; 0 freezes the prescaler (time-of-day freeze).
- btn_mode  in  1  mode button, already synchronised and debounced, level.
- btn_inc  in  1  increment button, already synchronised and debounced, level.
- sec_o  out  8  seconds BCD {tens[7:4], ones[3:0]}, range 00-59.
- min_o  out  8  minutes BCD, range 00-59.
- hr_o  out  8  hours BCD, range 00-23.
- mode_o  out  2  current mode: 0 RUN, 1 SET_HR, 2 SET_MIN.
- tick_o  out  1  one-cycle pulse, coincident with each RUN time update.
- day_o  out  1  one-cycle pulse, coincident with the 23:59:59 -> 00:00:00 update.
- blink_o  out  1  display blank phase for the field being set.

Behaviour:
- Reset (reset=0 sampled at a clk edge):
  - sec_o, min_o, hr_o = 00; mode_o = RUN.
  - tick_o = day_o = 0; prescaler = 0.
  - Button history registers = 1, so a button held through reset produces no edge.
- Button edges: rising edge = current level 1 and previous registered level 0. Each edge is acted on exactly once, in the cycle after the level rises.
- Prescaler:
  - Counts 0..TICK_DIV-1 while en=1, wrapping to 0; holds its value while en=0.
  - Runs in all modes.
- RUN mode, prescaler at TICK_DIV-1 with en=1:
  - Next edge increments seconds and asserts tick_o for that one cycle.
  - sec 59 -> 00 with carry to minutes; min 59 -> 00 with carry to hours; hr 23 -> 00 with day_o=1.
  - All carries resolve in the same cycle; there are no intermediate values such as 60 or 24.
- BCD arithmetic per digit pair:
  - ones 9 -> 0 with tens+1.
  - Wrap at the modulus: 60 for sec/min, 24 for hours, where hours 23 -> 00 and 19 -> 20.
  - Outputs are never outside their legal range.
- Mode FSM (advanced by btn_mode edges):
  - RUN -> SET_HR -> SET_MIN -> RUN.
  - Leaving SET_MIN: seconds cleared to 00 and prescaler cleared to 0 on the same edge.
  - Entering SET_HR: no state change other than mode.
- SET_HR: btn_inc edge increments hours mod 24 (23 -> 00). No day_o, no carry.
- SET_MIN: btn_inc edge increments minutes mod 60 (59 -> 00). No carry into hours.
- Set modes: seconds frozen; tick_o and day_o stay 0.
- Simultaneous btn_mode and btn_inc edges: mode advance wins; the increment is dropped.
- blink_o = (mode_o != RUN) & (prescaler < HALF_DIV). It is 0 in RUN.
- en=0 in RUN: time frozen, no ticks. Buttons and the FSM stay fully functional.
- Reset mid-operation: returns to the reset state on the next edge regardless of mode or prescaler value.
- Registered outputs: all outputs except blink_o are registered. blink_o is decoded from registers only.

Decomposition:
- Package clock_pkg:
  - mode enum (RUN, SET_HR, SET_MIN).
  - BCD constants: SEC_MAX=8'h59, MIN_MAX=8'h59, HR_MAX=8'h23.
  - BCD digit-pair type (8-bit).
- Sub-module bcd_mod_counter:
  - Parameter MAX_BCD.
  - Inputs: inc, clr. Outputs: 8-bit value, carry (combinational, = inc & value==MAX_BCD).
  - Instantiated three times.
- Top level holds the prescaler, button edge detectors, FSM and increment muxing.

Test Plan (TICK_DIV=4):
- Reset held 2 cycles, then en=1 for 12 cycles -> sec_o 00 -> 03. tick_o pulses every 4th cycle; no pulse before cycle 4.
- Preload via set mode to 23:59, exit, run 59 s -> 23:59:59. Next tick -> 00:00:00, with day_o=1 and tick_o=1 in the same cycle.
- btn_mode pulse -> mode_o=1. Three btn_inc pulses from hr 22 -> 23, 00, 01; min_o unchanged; tick_o stays 0 throughout.
- In SET_MIN, min 59 + btn_inc -> 00 with hr unchanged. btn_mode -> RUN, sec_o=00, first tick exactly 4 cycles later.
- btn_mode and btn_inc rise in the same cycle in SET_HR -> mode_o=2, hr_o unchanged. Button held 10 cycles -> a single action only.
- reset asserted mid-count at 12:34:56 in SET_MIN -> next edge all zero, mode_o=0. Button held through reset -> no action after release of reset.
